pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable, flush and bubble controls for PC, IF/ID and ID/EX registers.
- Detects load-use hazards and applies branch flushes.
- Sequences a multi-cycle mult/div unit through an issue/wait/release FSM with watchdog.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side hazard bus: status coming from the IF/ID and ID/EX
// registers plus the mult/div unit, and the control/counter outputs
// going back to them.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_memread_in;
    logic [4:0]       IDEX_Rt_in;
    logic [4:0]       IFID_Rs_in;
    logic [4:0]       IFID_Rt_in;
    logic             IFID_uses_rt_in;
    logic             branch_taken_in;
    logic             md_start_in;
    logic             md_done_in;
    logic             PC_write_out;
    logic             IFID_write_out;
    logic             IFID_flush_out;
    logic             IDEX_bubble_out;
    logic             md_go_out;
    logic             md_busy_out;
    logic             md_err_out;
    logic [CNT_W-1:0] stall_count_out;
    logic [CNT_W-1:0] flush_count_out;

    // Pipeline side: drives status, consumes controls
    modport master (
        output IDEX_memread_in, IDEX_Rt_in, IFID_Rs_in, IFID_Rt_in,
               IFID_uses_rt_in, branch_taken_in, md_start_in, md_done_in,
        input  PC_write_out, IFID_write_out, IFID_flush_out, IDEX_bubble_out,
               md_go_out, md_busy_out, md_err_out, stall_count_out, flush_count_out
    );

    // Controller side
    modport slave (
        input  IDEX_memread_in, IDEX_Rt_in, IFID_Rs_in, IFID_Rt_in,
               IFID_uses_rt_in, branch_taken_in, md_start_in, md_done_in,
        output PC_write_out, IFID_write_out, IFID_flush_out, IDEX_bubble_out,
               md_go_out, md_busy_out, md_err_out, stall_count_out, flush_count_out
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline: load-use
// stalls, branch flushes, mult/div issue/wait/release with a watchdog,
// and saturating stall/flush counters. Controls are combinational so a
// stall acts in the cycle the hazard is seen.
module pipe_hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    pipe_hazard_ctrl_if.slave    hz
);
    localparam int WD_W = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MD_BUSY, MD_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic lu;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, md_go, md_busy;
    logic flush_inc;

    // Load in EX writing a register the ID instruction reads ($0 never hazards)
    always_comb begin
        lu = hz.IDEX_memread_in && (hz.IDEX_Rt_in != 5'd0) &&
             ((hz.IDEX_Rt_in == hz.IFID_Rs_in) ||
              (hz.IFID_uses_rt_in && (hz.IDEX_Rt_in == hz.IFID_Rt_in)));
    end

    // Next state and same-cycle pipeline controls
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_go       = 1'b0;
        md_busy     = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        wd_d        = wd_q;
        err_d       = err_q;
        case (state_q)
            RUN: begin
                if (hz.branch_taken_in) begin
                    // Wrong-path instructions in IF/ID and ID get squashed
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (hz.md_start_in) begin
                    md_go       = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = MD_BUSY;
                    wd_d        = '0;
                end
            end
            MD_BUSY: begin
                // Hold the mult/div in ID; EX only sees bubbles so branches can't resolve
                md_busy     = 1'b1;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                wd_d        = wd_q + 1'b1;
                if (hz.md_done_in) begin
                    state_d = MD_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = MD_RELEASE;
                end
            end
            MD_RELEASE: begin
                // One free cycle lets the mult/div advance without re-issuing
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!RST_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            md_go       = 1'b0;
            md_busy     = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    // FSM, watchdog and sticky error register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Saturating performance counters
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            if (flush_inc && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.PC_write_out    = pc_write;
    assign hz.IFID_write_out  = ifid_write;
    assign hz.IFID_flush_out  = ifid_flush;
    assign hz.IDEX_bubble_out = idex_bubble;
    assign hz.md_go_out       = md_go;
    assign hz.md_busy_out     = md_busy;
    assign hz.md_err_out      = err_q;
    assign hz.stall_count_out = stall_q;
    assign hz.flush_count_out = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver applies one input vector per cycle, pushes the
// reference model's expected outputs, and a monitor compares them.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W      = 4;
    localparam int MD_TIMEOUT = 8;
    localparam int MAXC       = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pcw, ifw, ifl, bub, go, busy, err;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    logic CLK, RST_n;
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .CLK(CLK), .RST_n(RST_n), .hz(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   active = 0;

    // Reference model: mult/div tracked as "cycles spent waiting" plus a
    // pending-release flag; counters are plain saturating integers.
    int m_wait = -1;      // -1: no mult/div outstanding, else cycles waited
    bit m_release = 0;
    bit m_err = 0;
    int m_stall = 0, m_flush = 0;

    task automatic apply(input bit rst, input bit mr, input logic [4:0] idrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit br, input bit ms, input bit md);
        exp_t e;
        bit   hazard;
        @(negedge CLK);
        RST_n = rst;
        bus.IDEX_memread_in = mr;  bus.IDEX_Rt_in = idrt;
        bus.IFID_Rs_in = rs;       bus.IFID_Rt_in = rt;
        bus.IFID_uses_rt_in = urt; bus.branch_taken_in = br;
        bus.md_start_in = ms;      bus.md_done_in = md;
        if (!rst) begin
            m_wait = -1; m_release = 0; m_err = 0; m_stall = 0; m_flush = 0;
            e = '{pcw:0, ifw:0, ifl:1, bub:1, go:0, busy:0, err:0, sc:'0, fc:'0};
        end else begin
            e = '{pcw:1, ifw:1, ifl:0, bub:0, go:0, busy:0, err:m_err,
                  sc:CNT_W'(m_stall), fc:CNT_W'(m_flush)};
            hazard = mr && idrt != 0 && (idrt == rs || (urt && idrt == rt));
            if (m_release) begin
                m_release = 0;
            end else if (m_wait >= 0) begin
                e.busy = 1; e.pcw = 0; e.ifw = 0; e.bub = 1;
                if (md) begin
                    m_wait = -1; m_release = 1;
                end else if (m_wait == MD_TIMEOUT - 1) begin
                    m_err = 1; m_wait = -1; m_release = 1;
                end else begin
                    m_wait++;
                end
            end else if (br) begin
                e.ifl = 1; e.bub = 1;
                if (m_flush < MAXC) m_flush++;
            end else if (hazard) begin
                e.pcw = 0; e.ifw = 0; e.bub = 1;
            end else if (ms) begin
                e.go = 1; e.pcw = 0; e.ifw = 0; e.bub = 1;
                m_wait = 0;
            end
            if (!e.pcw && m_stall < MAXC) m_stall++;
        end
        active = 1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 2))
            0: return 5'd0;
            1: return 5'd5;
            default: return 5'd7;
        endcase
    endfunction

    // Monitor: outputs settle after the driver's negedge update
    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK);
            #2;
            if (active) begin
                vectors++;
                a = '{pcw:bus.PC_write_out, ifw:bus.IFID_write_out, ifl:bus.IFID_flush_out,
                      bub:bus.IDEX_bubble_out, go:bus.md_go_out, busy:bus.md_busy_out,
                      err:bus.md_err_out, sc:bus.stall_count_out, fc:bus.flush_count_out};
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t: got %b, no expectation", $time, a);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL outputs at %0t: got pcw/ifw/ifl/bub/go/busy/err=%b%b%b%b%b%b%b sc=%0d fc=%0d, exp %b%b%b%b%b%b%b sc=%0d fc=%0d",
                                 $time, a.pcw, a.ifw, a.ifl, a.bub, a.go, a.busy, a.err, a.sc, a.fc,
                                 e.pcw, e.ifw, e.ifl, e.bub, e.go, e.busy, e.err, e.sc, e.fc);
                    end
                end
            end
        end
    end

    initial begin
        RST_n = 1'b0;
        bus.IDEX_memread_in = 0; bus.IDEX_Rt_in = 0; bus.IFID_Rs_in = 0;
        bus.IFID_Rt_in = 0; bus.IFID_uses_rt_in = 0; bus.branch_taken_in = 0;
        bus.md_start_in = 0; bus.md_done_in = 0;
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on Rs, then same with $0 destination
        apply(1, 1, 5, 5, 0, 0, 0, 0, 0);
        idle(1);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Rt compare only when the ID instruction reads Rt
        apply(1, 1, 5, 3, 5, 0, 0, 0, 0);
        apply(1, 1, 5, 3, 5, 1, 0, 0, 0);
        // branch wins over load-use and mult/div start
        apply(1, 1, 5, 5, 0, 0, 1, 1, 0);
        idle(1);
        // mult/div: start held, done three cycles after go
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1);
        apply(1, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(2);
        // watchdog: done never arrives
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(12);
        // done coinciding with the last watchdog cycle counts as done
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(MD_TIMEOUT - 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // counter saturation under a held load-use stall
        for (int i = 0; i < 20; i++) apply(1, 1, 7, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // reset dropped mid-MD_BUSY
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        apply(0, 1, 5, 5, 5, 1, 1, 1, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 79) != 0), $urandom_range(0, 1), rreg(), rreg(), rreg(),
                  $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        #5;
        active = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
